// File: rtl/qnigma_pkg.sv
// Shared TCP definitions: window-scale limits, scale types and the window-tracker FSM states.
package qnigma_pkg;

  // RFC 7323 caps the window-scale shift count at 14.
  localparam int TCP_WND_SCL_MAX = 14;
  // Internal accumulator width: a 16-bit window shifted by 14 needs 30 bits.
  localparam int TCP_WND_ACC_W   = 30;

  // Shift count exactly as received in the WS option.
  typedef logic [3:0] tcp_scl_t;
  // Shift count after clamping; always <= TCP_WND_SCL_MAX.
  typedef logic [3:0] tcp_wnd_scl_t;

  typedef enum logic [1:0] {
    WND_IDLE,
    WND_SHIFT,
    WND_DONE
  } tcp_wnd_fsm_t;

  // Limit a received shift count to the largest value TCP allows.
  function automatic tcp_wnd_scl_t tcp_wnd_scl_clamp(input tcp_scl_t s);
    if (s > tcp_scl_t'(TCP_WND_SCL_MAX)) return tcp_wnd_scl_t'(TCP_WND_SCL_MAX);
    return tcp_wnd_scl_t'(s);
  endfunction

endpackage

// File: rtl/qnigma_tcp_wnd_shf.sv
// Shared window shift engine: shifts a raw 16-bit window left by a latched scale and saturates
// the result to WND_W bits. With QNIGMA_TCP_WND_FAST_EN defined the engine is a single-cycle
// barrel shifter that accepts every cycle; otherwise it shifts one bit per cycle.
// fin marks the clock edge at which res must be captured by the caller.
module qnigma_tcp_wnd_shf
  import qnigma_pkg::*;
#(
  parameter int WND_W = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        raw,
  input  tcp_wnd_scl_t       scl,
  output logic               rdy,
  output logic               busy,
  output logic               fin,
  output logic [WND_W-1:0]   res
);

  localparam logic [TCP_WND_ACC_W-1:0] WND_MAX =
    TCP_WND_ACC_W'((64'd1 << WND_W) - 64'd1);

  function automatic logic [WND_W-1:0] sat(input logic [TCP_WND_ACC_W-1:0] a);
    if (a > WND_MAX) return '1;
    return a[WND_W-1:0];
  endfunction

`ifdef QNIGMA_TCP_WND_FAST_EN

  logic [TCP_WND_ACC_W-1:0] shf;

  // Whole shift in one cycle; the result is captured at the accept edge.
  always_comb begin
    shf  = TCP_WND_ACC_W'(raw) << scl;
    rdy  = 1'b1;
    busy = 1'b0;
    fin  = start;
    res  = sat(shf);
  end

`else

  tcp_wnd_fsm_t             state_q, state_d;
  logic [TCP_WND_ACC_W-1:0] acc_q, acc_d;
  tcp_wnd_scl_t             ctr_q, ctr_d;
  tcp_wnd_scl_t             lat_q, lat_d;

  // Engine state, accumulator, shift counter and latched scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WND_IDLE;
      acc_q   <= '0;
      ctr_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ctr_q   <= ctr_d;
      lat_q   <= lat_d;
    end
  end

  // One shift per SHIFT cycle; fin fires on the edge that enters DONE so the result is
  // visible together with done. A zero scale needs no shifting and goes straight to DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ctr_d   = ctr_q;
    lat_d   = lat_q;
    rdy     = 1'b0;
    busy    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      WND_IDLE: begin
        rdy = 1'b1;
        if (start) begin
          acc_d = TCP_WND_ACC_W'(raw);
          ctr_d = '0;
          lat_d = scl;
          if (scl == '0) begin
            fin     = 1'b1;
            state_d = WND_DONE;
          end else begin
            state_d = WND_SHIFT;
          end
        end
      end
      WND_SHIFT: begin
        busy  = 1'b1;
        acc_d = acc_q << 1;
        ctr_d = ctr_q + 4'd1;
        if (ctr_d == lat_q) begin
          fin     = 1'b1;
          state_d = WND_DONE;
        end
      end
      WND_DONE: begin
        state_d = WND_IDLE;
      end
      default: begin
        state_d = WND_IDLE;
      end
    endcase
    res = sat(acc_d);
  end

`endif

endmodule

// File: rtl/qnigma_tcp_wnd_trk.sv
// Multi-connection tracker of the remote TCP receive window. Holds per-channel window scale,
// scaled window and valid flag; one shared qnigma_tcp_wnd_shf engine computes all updates.
// QNIGMA_TCP_WND_FAST_EN selects the single-cycle engine (see qnigma_tcp_wnd_shf).
module qnigma_tcp_wnd_trk
  import qnigma_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WND_W = 30,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_scl,
  input  logic [CH_W-1:0]            set_ch,
  input  logic [3:0]                 scl,
  input  logic                       upd_val,
  output logic                       upd_rdy,
  input  logic [CH_W-1:0]            upd_ch,
  input  logic [15:0]                raw,
  input  logic                       clr,
  input  logic [CH_W-1:0]            clr_ch,
  output logic [N_CH-1:0][WND_W-1:0] wnd,
  output logic [N_CH-1:0]            wnd_ok,
  output logic                       done,
  output logic [CH_W-1:0]            done_ch
);

  if (WND_W < 16 || WND_W > TCP_WND_ACC_W || N_CH < 1) begin : g_param_chk
    $error("qnigma_tcp_wnd_trk: WND_W must be 16..30 and N_CH >= 1");
  end

  tcp_wnd_scl_t [N_CH-1:0]        scl_q, scl_d;
  logic [N_CH-1:0][WND_W-1:0]     wnd_q, wnd_d;
  logic [N_CH-1:0]                ok_q, ok_d;
  logic                           done_q, done_d;
  logic [CH_W-1:0]                done_ch_q, done_ch_d;
  logic [CH_W-1:0]                ch_q, ch_d;
  logic                           kill_q, kill_d;

  logic                           accept;
  logic [CH_W-1:0]                fly_ch;
  logic                           fly_clr;
  tcp_wnd_scl_t                   eff_scl;
  logic                           eng_rdy, eng_busy, eng_fin;
  logic [WND_W-1:0]               eng_res;

  // Per-channel state plus the channel and discard flag of the calculation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q     <= '0;
      wnd_q     <= '0;
      ok_q      <= '0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
      ch_q      <= '0;
      kill_q    <= 1'b0;
    end else begin
      scl_q     <= scl_d;
      wnd_q     <= wnd_d;
      ok_q      <= ok_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
      ch_q      <= ch_d;
      kill_q    <= kill_d;
    end
  end

  // Scale storage (clear beats load) and arbitration; an accept sees this cycle's new scale.
  always_comb begin
    accept  = upd_val & eng_rdy;
    fly_ch  = eng_busy ? ch_q : upd_ch;
    fly_clr = clr && (clr_ch == fly_ch);
    ch_d    = accept ? upd_ch : ch_q;
    if (accept)        kill_d = fly_clr;
    else if (eng_busy) kill_d = kill_q | fly_clr;
    else               kill_d = 1'b0;
    scl_d   = scl_q;
    eff_scl = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (clr && clr_ch == CH_W'(i))              scl_d[i] = '0;
      else if (set_scl && set_ch == CH_W'(i))     scl_d[i] = tcp_wnd_scl_clamp(scl);
    end
    for (int i = 0; i < N_CH; i++) begin
      if (upd_ch == CH_W'(i)) eff_scl = scl_d[i];
    end
  end

  qnigma_tcp_wnd_shf #(.WND_W(WND_W)) u_shf (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .raw   (raw),
    .scl   (eff_scl),
    .rdy   (eng_rdy),
    .busy  (eng_busy),
    .fin   (eng_fin),
    .res   (eng_res)
  );

  // Capture the engine result unless its channel was cleared while in flight; a clear wins.
  always_comb begin
    wnd_d = wnd_q;
    ok_d  = ok_q;
    for (int i = 0; i < N_CH; i++) begin
      if (eng_fin && !kill_d && fly_ch == CH_W'(i)) begin
        wnd_d[i] = eng_res;
        ok_d[i]  = 1'b1;
      end
      if (clr && clr_ch == CH_W'(i)) begin
        wnd_d[i] = '0;
        ok_d[i]  = 1'b0;
      end
    end
    done_d    = eng_fin;
    done_ch_d = eng_fin ? fly_ch : done_ch_q;
  end

  assign upd_rdy = eng_rdy;
  assign wnd     = wnd_q;
  assign wnd_ok  = ok_q;
  assign done    = done_q;
  assign done_ch = done_ch_q;

endmodule

// File: tb/tb_qnigma_tcp_wnd_trk.sv
// Testbench for qnigma_tcp_wnd_trk: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level reference model. Honours QNIGMA_TCP_WND_FAST_EN.
module tb_qnigma_tcp_wnd_trk;

  localparam int N_CH  = 4;
  localparam int WND_W = 30;
`ifdef QNIGMA_TCP_WND_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam longint WMAX = (longint'(1) << WND_W) - 1;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       set_scl = 1'b0;
  logic [1:0]                 set_ch = '0;
  logic [3:0]                 scl = '0;
  logic                       upd_val = 1'b0;
  logic                       upd_rdy;
  logic [1:0]                 upd_ch = '0;
  logic [15:0]                raw = '0;
  logic                       clr = 1'b0;
  logic [1:0]                 clr_ch = '0;
  logic [N_CH-1:0][WND_W-1:0] wnd;
  logic [N_CH-1:0]            wnd_ok;
  logic                       done;
  logic [1:0]                 done_ch;

  logic                       s24_set = 1'b0;
  logic [3:0]                 s24_scl = '0;
  logic                       s24_val = 1'b0;
  logic [15:0]                s24_raw = '0;
  logic                       d24_rdy;
  logic [1:0][23:0]           d24_wnd;
  logic [1:0]                 d24_ok;
  logic                       d24_done;
  logic                       d24_done_ch;

  int vectors = 0;
  int miscompares = 0;

  // reference model state (values expected on the DUT outputs in the current cycle)
  int     m_scl [N_CH];
  longint m_wnd [N_CH];
  bit     m_ok  [N_CH];
  bit     m_done;
  int     m_done_ch;
  bit     m_rdy;
  int     m_left;
  int     m_ch;
  longint m_res;
  bit     m_kill;
  bit     m_cool;

  qnigma_tcp_wnd_trk #(.N_CH(N_CH), .WND_W(WND_W)) u_dut (
    .clk(clk), .rst(rst), .set_scl(set_scl), .set_ch(set_ch), .scl(scl),
    .upd_val(upd_val), .upd_rdy(upd_rdy), .upd_ch(upd_ch), .raw(raw),
    .clr(clr), .clr_ch(clr_ch), .wnd(wnd), .wnd_ok(wnd_ok), .done(done), .done_ch(done_ch)
  );

  qnigma_tcp_wnd_trk #(.N_CH(2), .WND_W(24)) u_dut24 (
    .clk(clk), .rst(rst), .set_scl(s24_set), .set_ch(1'b0), .scl(s24_scl),
    .upd_val(s24_val), .upd_rdy(d24_rdy), .upd_ch(1'b0), .raw(s24_raw),
    .clr(1'b0), .clr_ch(1'b0), .wnd(d24_wnd), .wnd_ok(d24_ok), .done(d24_done),
    .done_ch(d24_done_ch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int expLat(input int s);
    return FAST ? 1 : s + 1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N_CH; i++) begin
      m_scl[i] = 0; m_wnd[i] = 0; m_ok[i] = 1'b0;
    end
    m_done = 1'b0; m_done_ch = 0; m_rdy = 1'b1;
    m_left = 0; m_ch = 0; m_res = 0; m_kill = 1'b0; m_cool = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare all outputs.
  task automatic applyStimulus(input bit i_rst, input bit i_set, input int i_sch, input int i_scl,
                               input bit i_upd, input int i_uch, input int i_raw,
                               input bit i_clr, input int i_cch);
    bit accept;
    bit fin;
    rst = i_rst; set_scl = i_set; set_ch = 2'(i_sch); scl = 4'(i_scl);
    upd_val = i_upd; upd_ch = 2'(i_uch); raw = 16'(i_raw);
    clr = i_clr; clr_ch = 2'(i_cch);
    if (i_rst) begin
      modelReset();
    end else begin
      accept = i_upd && m_rdy;
      fin = 1'b0;
      if (m_left > 0 && i_clr && i_cch == m_ch) m_kill = 1'b1;
      if (i_set && !(i_clr && i_cch == i_sch)) m_scl[i_sch] = (i_scl > 14) ? 14 : i_scl;
      if (i_clr) m_scl[i_cch] = 0;
      if (accept) begin
        m_ch   = i_uch;
        m_res  = longint'(i_raw) * (longint'(1) << m_scl[i_uch]);
        if (m_res > WMAX) m_res = WMAX;
        m_left = FAST ? 1 : m_scl[i_uch] + 1;
        m_kill = i_clr && i_cch == i_uch;
        m_rdy  = FAST;
      end else if (m_cool) begin
        m_rdy  = 1'b1;
        m_cool = 1'b0;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          fin = 1'b1;
          m_done_ch = m_ch;
          if (!m_kill) begin
            m_wnd[m_ch] = m_res;
            m_ok[m_ch]  = 1'b1;
          end
          if (!FAST) m_cool = 1'b1;
        end
      end
      if (i_clr) begin
        m_wnd[i_cch] = 0;
        m_ok[i_cch]  = 1'b0;
      end
      m_done = fin;
    end
    @(posedge clk);
    #1;
    checkOutput("upd_rdy", 32'(upd_rdy), 32'(m_rdy));
    checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("done_ch", 32'(done_ch), 32'(m_done_ch));
    for (int i = 0; i < N_CH; i++) begin
      checkOutput($sformatf("wnd[%0d]", i), 32'(wnd[i]), 32'(m_wnd[i]));
      checkOutput($sformatf("wnd_ok[%0d]", i), 32'(wnd_ok[i]), 32'(m_ok[i]));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Cycles from accept until done is seen (1 = the cycle right after accept), -1 on timeout.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      idle(1);
    end
  endtask

  // One scale load + one update on the 24-bit instance.
  task automatic run24(input int s, input int r, output logic [31:0] w, output int lat);
    s24_set = 1'b1; s24_scl = 4'(s); idle(1); s24_set = 1'b0;
    s24_val = 1'b1; s24_raw = 16'(r); idle(1); s24_val = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (d24_done) begin
        lat = k;
        break;
      end
      idle(1);
    end
    w = 32'(d24_wnd[0]);
  endtask

  initial begin
    int lat;
    int waits;
    int nd;
    logic [31:0] w;
    bit p_val;
    int p_ch;
    int p_raw;

    modelReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_wnd_ok", 32'(wnd_ok), 32'h0);
    checkOutput("rst_upd_rdy", 32'(upd_rdy), 32'h1);
    idle(1);

    // scale 14, full raw window
    applyStimulus(0, 1, 0, 14, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 16'hFFFF, 0, 0);
    waitDone(lat);
    checkOutput("t1_lat", 32'(lat), 32'(expLat(14)));
    checkOutput("t1_wnd", 32'(wnd[0]), 32'h3FFF_C000);
    idle(1);

    // clamping 15 -> 14, scale 0, load and update in the same cycle
    applyStimulus(0, 1, 1, 15, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 16'h0001, 0, 0);
    waitDone(lat);
    checkOutput("t2_clamp_lat", 32'(lat), 32'(expLat(14)));
    checkOutput("t2_clamp_wnd", 32'(wnd[1]), 32'h0000_4000);
    idle(1);
    applyStimulus(0, 0, 0, 0, 1, 3, 16'h1234, 0, 0);
    waitDone(lat);
    checkOutput("t2_s0_lat", 32'(lat), 32'(expLat(0)));
    checkOutput("t2_s0_wnd", 32'(wnd[3]), 32'h0000_1234);
    idle(1);
    applyStimulus(0, 1, 2, 3, 1, 2, 16'h0005, 0, 0);
    waitDone(lat);
    checkOutput("t2_same_lat", 32'(lat), 32'(expLat(3)));
    checkOutput("t2_same_wnd", 32'(wnd[2]), 32'h0000_0028);
    idle(1);

    // saturation on a 24-bit instance
    run24(9, 16'h8000, w, lat);
    checkOutput("t3_sat_wnd", w, 32'h00FF_FFFF);
    checkOutput("t3_sat_lat", 32'(lat), 32'(expLat(9)));
    run24(8, 16'h8000, w, lat);
    checkOutput("t3_fit_wnd", w, 32'h0080_0000);
    run24(14, 16'h03FF, w, lat);
    checkOutput("t3_edge_wnd", w, 32'h00FF_C000);
    run24(14, 16'h0400, w, lat);
    checkOutput("t3_over_wnd", w, 32'h00FF_FFFF);
    checkOutput("t3_ok", 32'(d24_ok), 32'h1);
    idle(1);

    // second request held while the engine is busy
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0003, 0, 0);
    waits = 0;
    for (int k = 0; k < 40; k++) begin
      bit was_rdy;
      was_rdy = m_rdy;
      applyStimulus(0, 0, 0, 0, 1, 1, 16'h0002, 0, 0);
      if (was_rdy) break;
      waits++;
    end
    checkOutput("t4_wait", 32'(waits), FAST ? 32'd0 : 32'd15);
    waitDone(lat);
    checkOutput("t4_lat", 32'(lat), 32'(expLat(14)));
    checkOutput("t4_wnd0", 32'(wnd[0]), 32'h0000_C000);
    checkOutput("t4_wnd1", 32'(wnd[1]), 32'h0000_8000);
    idle(1);

`ifndef QNIGMA_TCP_WND_FAST_EN
    // clear of the in-flight channel discards; clear of another channel does not
    applyStimulus(0, 1, 2, 10, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 2, 16'h0007, 0, 0);
    idle(3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2);
    waitDone(lat);
    checkOutput("t5_done_seen", 32'(lat > 0), 32'h1);
    checkOutput("t5_kill_wnd", 32'(wnd[2]), 32'h0);
    checkOutput("t5_kill_ok", 32'(wnd_ok[2]), 32'h0);
    idle(1);
    applyStimulus(0, 1, 2, 10, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 2, 16'h0007, 0, 0);
    idle(3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3);
    waitDone(lat);
    checkOutput("t5_keep_wnd", 32'(wnd[2]), 32'h0000_1C00);
    checkOutput("t5_keep_ok", 32'(wnd_ok[2]), 32'h1);
    idle(1);

    // reset in the middle of a calculation
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0001, 0, 0);
    idle(5);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (done) nd++;
    end
    checkOutput("t6_no_done", 32'(nd), 32'h0);
    checkOutput("t6_ok", 32'(wnd_ok), 32'h0);
`else
    // clear in the accept cycle discards the one-cycle result
    applyStimulus(0, 0, 0, 0, 1, 2, 16'h0007, 1, 2);
    checkOutput("t5_fast_done", 32'(done), 32'h1);
    checkOutput("t5_fast_wnd", 32'(wnd[2]), 32'h0);
    // back-to-back updates
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, i, i + 1, 0, 0);
      if (done) nd++;
    end
    checkOutput("t6_fast_b2b", 32'(nd), 32'h4);
`endif

    // randomized traffic with held requests
    p_val = 1'b0; p_ch = 0; p_raw = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      bit r, s_en, c_en, acc;
      int s_ch, s_v, c_ch;
      r    = ($urandom_range(0, 299) == 0);
      s_en = ($urandom_range(0, 7) == 0);
      s_ch = $urandom_range(0, N_CH - 1);
      s_v  = $urandom_range(0, 15);
      c_en = ($urandom_range(0, 15) == 0);
      c_ch = $urandom_range(0, N_CH - 1);
      if (!p_val && $urandom_range(0, 2) == 0) begin
        p_val = 1'b1;
        p_ch  = $urandom_range(0, N_CH - 1);
        case ($urandom_range(0, 3))
          0:       p_raw = 16'hFFFF;
          1:       p_raw = $urandom_range(0, 3);
          default: p_raw = $urandom_range(0, 65535);
        endcase
      end
      acc = p_val && m_rdy && !r;
      applyStimulus(r, s_en, s_ch, s_v, p_val, p_ch, p_raw, c_en, c_ch);
      if (acc) p_val = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
